// File: rtl/conway_window_gen.sv
// conway_window_gen: streams a raster bit grid and emits zero-padded 3x3 neighbourhoods in raster order.
module conway_window_gen #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int CW = $clog2(WIDTH + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    top_row,
    output logic [2:0]    middle_row,
    output logic [2:0]    bottom_row,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          frame_done
);
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t state, state_nx;
    logic [2*WIDTH+2:0] sr, sr_nx;
    logic [CW-1:0] cnt;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic out_free, adv, load, last_x, last_y;
    logic [2:0] mask, top_nx, mid_nx, bot_nx;
    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = state == FILL || (state == RUN && out_free);
        adv      = state == FLUSH ? out_free : in_valid && in_ready;
        load     = adv && state != FILL;
        sr_nx    = {sr[2*WIDTH+1:0], state != FLUSH && in_bit};
        last_x   = cx == XW'(WIDTH - 1);
        last_y   = cy == YW'(HEIGHT - 1);
        // cx/cy name the centre being loaded by this advance
        mask     = {cx != '0, 1'b1, !last_x};
        top_nx   = cy == '0 ? 3'b000 : sr_nx[2*WIDTH+2 -: 3] & mask;
        mid_nx   = sr_nx[WIDTH+2 -: 3] & mask;
        bot_nx   = last_y ? 3'b000 : sr_nx[2:0] & mask;
        state_nx = state;
        if (adv) begin
            if (state == FILL && cnt == CW'(WIDTH))
                state_nx = RUN;
            else if (state == RUN && cx == XW'(WIDTH - 2) && cy == YW'(HEIGHT - 2))
                state_nx = FLUSH;
            else if (state == FLUSH && last_x && last_y)
                state_nx = FILL;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            sr         <= '0;
            cnt        <= '0;
            cx         <= '0;
            cy         <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            top_row    <= '0;
            middle_row <= '0;
            bottom_row <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= out_valid && out_ready && out_x == XW'(WIDTH - 1) && out_y == YW'(HEIGHT - 1);
            cnt        <= state == FILL ? cnt + CW'(adv) : '0;
            if (adv)
                sr <= sr_nx;
            if (load) begin
                top_row    <= top_nx;
                middle_row <= mid_nx;
                bottom_row <= bot_nx;
                out_x      <= cx;
                out_y      <= cy;
                out_valid  <= 1'b1;
                cx         <= last_x ? '0 : cx + 1'b1;
                if (last_x)
                    cy <= last_y ? '0 : cy + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/conway_window_gen.md
CONWAY_WINDOW_GEN -- requirements
Module: conway_window_gen

Interface
REQ-001 Parameter WIDTH, default 64, grid columns (>=3).
REQ-002 Parameter HEIGHT, default 48, grid rows (>=3).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_bit carries the next raster-order cell.
REQ-006 in_ready  output  1  block accepts in_bit this cycle.
REQ-007 in_bit  input  1  current-generation cell state, row-major, x fastest.
REQ-008 out_valid  output  1  window registers hold a valid neighbourhood.
REQ-009 out_ready  input  1  downstream cell consumes the window this cycle.
REQ-010 top_row, middle_row, bottom_row  output  3 each  neighbourhood of rows y-1, y, y+1; bit[2]=x-1, bit[1]=x, bit[0]=x+1.
REQ-011 out_x  output  clog2(WIDTH)  centre column; out_y  output  clog2(HEIGHT)  centre row.
REQ-012 frame_done  output  1  one-cycle pulse on acceptance of window (WIDTH-1, HEIGHT-1).

Function
REQ-013 Block SHALL hold a shift register of 2*WIDTH+3 bits; each advance shifts in one bit, sr[k] = bit advanced k steps earlier.
REQ-014 Taps SHALL be: bottom = {sr[2],sr[1],sr[0]}; middle = {sr[W+2],sr[W+1],sr[W]}; top = {sr[2W+2],sr[2W+1],sr[2W]}.
REQ-015 Out-of-grid neighbours SHALL read 0: bit[2] of all rows masked when x=0; bit[0] masked when x=WIDTH-1; top_row forced 0 when y=0; bottom_row forced 0 when y=HEIGHT-1.
REQ-016 States SHALL be FILL, RUN, FLUSH.
REQ-017 FILL: in_ready=1; accepted bits shift in, no window emitted; after WIDTH+1 accepted bits -> RUN.
REQ-018 RUN: each accepted bit shifts in and loads a window for the centre WIDTH+1 positions earlier; after the last input bit (index WIDTH*HEIGHT-1) -> FLUSH.
REQ-019 FLUSH: in_ready=0; block shifts in WIDTH+1 internal zeros, one per advance, each loading a window; after the last -> FILL, centre counters cleared.
REQ-020 Output stage SHALL be a single register: an advance that loads a window occurs only when out_valid=0 or out_ready=1.
REQ-021 in_ready SHALL be 1 in FILL; 1 in RUN only when out_valid=0 or out_ready=1; 0 in FLUSH.
REQ-022 Latency: window for centre c SHALL appear with out_valid=1 the cycle after acceptance of input c+WIDTH+1 (or the matching flush step).
REQ-023 While out_valid=1 and out_ready=0, all window outputs, out_x and out_y SHALL hold stable.
REQ-024 Windows SHALL be emitted in raster order, exactly WIDTH*HEIGHT per frame, none dropped or duplicated.
REQ-025 out_x SHALL wrap WIDTH-1 -> 0 with out_y increment; out_y wraps HEIGHT-1 -> 0 at frame end.
REQ-026 Back-to-back frames: first input of next frame SHALL be accepted the cycle after the FLUSH->FILL transition; no previous-frame data SHALL affect new windows (masking per REQ-015).
REQ-027 frame_done SHALL be registered, asserted exactly one cycle after the final window handshake.

Reset
REQ-028 reset SHALL asynchronously force: state FILL, shift register all 0, out_valid=0, frame_done=0, counters 0, window outputs 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next accepted bit is cell (0,0).

Verification
REQ-031 Reset: assert reset mid-RUN -> same cycle out_valid=0, frame_done=0; after release in_ready=1, next window is (0,0).
REQ-032 W=4,H=3, single 1 at (1,1), out_ready=1 -> 12 windows; (0,0): top=000 middle=000 bottom=001; (1,1): middle=010, others 000; (2,2): top=100.
REQ-033 W=4,H=3 all ones -> (0,0): 000/011/011; (1,1): 111/111/111; (3,2): 110/110/000; frame_done one pulse.
REQ-034 Backpressure: out_ready=0 for 10 cycles mid-RUN -> out_valid stays 1, outputs stable, in_ready=0, no bit lost; resume yields correct sequence.
REQ-035 Back-to-back frames: all-ones then all-zeros, in_valid=1 continuously -> second frame all windows 000/000/000, in_ready=0 for exactly WIDTH+1 flush advances between frames.
REQ-036 Random in_valid/out_ready throttling over 3 frames -> windows match a software 3x3 zero-padded model, in order.
